// File: rtl/add_pkg.sv
// Shared definitions for the add operand pairer: FSM state encoding and counter width.
package add_pkg;

    localparam int PAIR_CNT_W = 16;
    localparam logic [PAIR_CNT_W-1:0] PAIR_CNT_ONE = PAIR_CNT_W'(1);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } pair_state_e;

endpackage

// File: rtl/add_operand_pairer.sv
// Groups a serial operand stream into (in1, in2) pairs for a downstream add stage,
// padding a lone trailing word with zero and counting handed-off pairs.
module add_operand_pairer
    import add_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      s_data,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic [WIDTH-1:0]      in1,
    output logic [WIDTH-1:0]      in2,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  m_pad,
    output logic [PAIR_CNT_W-1:0] pair_cnt
);

    pair_state_e             state_q;
    logic [WIDTH-1:0]        in1_q;
    logic [WIDTH-1:0]        in2_q;
    logic                    m_last_q;
    logic                    m_pad_q;
    logic [PAIR_CNT_W-1:0]   pair_cnt_q;
    logic                    in_hs;
    logic                    out_hs;

    // While a pair is presented, a new word may only enter as the old pair leaves.
    assign s_ready = !rst && ((state_q != FULL) || m_ready);
    assign m_valid = !rst && (state_q == FULL);
    assign in_hs   = s_valid && s_ready;
    assign out_hs  = m_valid && m_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            in1_q      <= '0;
            in2_q      <= '0;
            m_last_q   <= 1'b0;
            m_pad_q    <= 1'b0;
            pair_cnt_q <= '0;
        end else begin
            if (out_hs) begin
                pair_cnt_q <= pair_cnt_q + PAIR_CNT_ONE;
            end
            unique case (state_q)
                // FULL only accepts a word together with an output handshake,
                // so it then behaves exactly like EMPTY.
                EMPTY, FULL: begin
                    if (in_hs) begin
                        in1_q <= s_data;
                        if (s_last) begin
                            in2_q    <= '0;
                            m_pad_q  <= 1'b1;
                            m_last_q <= 1'b1;
                            state_q  <= FULL;
                        end else begin
                            state_q  <= HALF;
                        end
                    end else if (out_hs) begin
                        state_q <= EMPTY;
                    end
                end
                HALF: begin
                    if (in_hs) begin
                        in2_q    <= s_data;
                        m_pad_q  <= 1'b0;
                        m_last_q <= s_last;
                        state_q  <= FULL;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                end
            endcase
        end
    end

    assign in1      = in1_q;
    assign in2      = in2_q;
    assign m_last   = m_last_q;
    assign m_pad    = m_pad_q;
    assign pair_cnt = pair_cnt_q;

endmodule

// File: tb/tb_add_operand_pairer.sv
// Self-checking bench: directed scenarios with literal expectations plus random
// streams compared each cycle against a queue-based pairing model.
module tb_add_operand_pairer;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] s_data;
    logic             s_valid;
    logic             s_last;
    logic             s_ready;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             m_valid;
    logic             m_ready;
    logic             m_last;
    logic             m_pad;
    logic [15:0]      pair_cnt;

    add_operand_pairer #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_last   (s_last),
        .s_ready  (s_ready),
        .in1      (in1),
        .in2      (in2),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_last   (m_last),
        .m_pad    (m_pad),
        .pair_cnt (pair_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             last;
        logic             pad;
    } pair_t;

    int          n_checks = 0;
    int          n_fail   = 0;

    // Reference model: pairs waiting for hand-off, a held first word, a pair counter.
    pair_t            exp_q[$];
    logic             mdl_held_v = 1'b0;
    logic [WIDTH-1:0] mdl_held;
    logic [15:0]      mdl_cnt = '0;
    logic             exp_zero = 1'b0;
    logic [WIDTH-1:0] acc_sum = '0;
    int               mdl_pairs = 0;
    logic [WIDTH-1:0] dut_sum = '0;
    int               dut_pairs = 0;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Compare process: checks outputs at the falling edge, then advances the model
    // by whatever handshakes the next rising edge will see.
    logic  exp_sr;
    logic  mdl_out_hs;
    logic  mdl_in_hs;
    pair_t np;
    always @(negedge clk) begin
        exp_sr = !rst && !(exp_q.size() != 0 && !m_ready);
        check("s_ready", WIDTH'(s_ready), WIDTH'(exp_sr));
        check("m_valid", WIDTH'(m_valid), WIDTH'(!rst && exp_q.size() != 0));
        check("pair_cnt", WIDTH'(pair_cnt), WIDTH'(mdl_cnt));
        if (!rst && exp_q.size() != 0) begin
            check("in1", in1, exp_q[0].a);
            check("in2", in2, exp_q[0].b);
            check("m_last", WIDTH'(m_last), WIDTH'(exp_q[0].last));
            check("m_pad", WIDTH'(m_pad), WIDTH'(exp_q[0].pad));
        end
        if (exp_zero) begin
            check("rst_in1", in1, '0);
            check("rst_in2", in2, '0);
            check("rst_m_last", WIDTH'(m_last), '0);
            check("rst_m_pad", WIDTH'(m_pad), '0);
        end
        if (!rst && m_valid && m_ready) begin
            dut_sum   = dut_sum + in1 + in2;
            dut_pairs = dut_pairs + 1;
        end

        if (rst) begin
            exp_q.delete();
            mdl_held_v = 1'b0;
            mdl_cnt    = '0;
            exp_zero   = 1'b1;
        end else begin
            mdl_out_hs = (exp_q.size() != 0) && m_ready;
            mdl_in_hs  = s_valid && exp_sr;
            if (mdl_out_hs) begin
                void'(exp_q.pop_front());
                mdl_cnt = mdl_cnt + 16'd1;
            end
            if (mdl_in_hs) begin
                exp_zero = 1'b0;
                acc_sum  = acc_sum + s_data;
                if (mdl_held_v) begin
                    np.a = mdl_held; np.b = s_data; np.last = s_last; np.pad = 1'b0;
                    exp_q.push_back(np);
                    mdl_pairs++;
                    mdl_held_v = 1'b0;
                end else if (s_last) begin
                    np.a = s_data; np.b = '0; np.last = 1'b1; np.pad = 1'b1;
                    exp_q.push_back(np);
                    mdl_pairs++;
                end else begin
                    mdl_held   = s_data;
                    mdl_held_v = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one word and returns just after the rising edge that accepted it.
    task automatic send_word(input logic [WIDTH-1:0] d, input logic l);
        bit ok = 1'b0;
        int budget = 0;
        s_valid = 1'b1; s_data = d; s_last = l;
        while (!ok && budget < 50) begin
            @(negedge clk);
            ok = s_ready;
            tick();
            budget++;
        end
        s_valid = 1'b0; s_last = 1'b0;
        if (!ok) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    logic [15:0]      cnt0;
    logic [WIDTH-1:0] sum0;
    int               pairs0;
    int               dpairs0;
    logic [WIDTH-1:0] dsum0;
    int               stalls;

    initial begin
        rst = 1'b1; s_data = '0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
        do_reset();
        check("reset_cnt", WIDTH'(pair_cnt), 32'd0);
        check("reset_m_valid", WIDTH'(m_valid), 32'd0);

        // Two-word stream 5,7
        send_word(32'd5, 1'b0);
        send_word(32'd7, 1'b1);
        check("p57_valid", WIDTH'(m_valid), 32'd1);
        check("p57_in1", in1, 32'd5);
        check("p57_in2", in2, 32'd7);
        check("p57_last", WIDTH'(m_last), 32'd1);
        check("p57_pad", WIDTH'(m_pad), 32'd0);
        tick();
        check("p57_cnt", WIDTH'(pair_cnt), 32'd1);

        // Lone last word gets zero padding
        send_word(32'd9, 1'b1);
        check("p9_in1", in1, 32'd9);
        check("p9_in2", in2, 32'd0);
        check("p9_pad", WIDTH'(m_pad), 32'd1);
        check("p9_last", WIDTH'(m_last), 32'd1);
        tick();

        // Back-pressure on a presented pair, then simultaneous hand-off and accept
        m_ready = 1'b0;
        send_word(32'd3, 1'b0);
        send_word(32'd4, 1'b0);
        s_valid = 1'b1; s_data = 32'd10; s_last = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("bp_s_ready", WIDTH'(s_ready), 32'd0);
            check("bp_in1", in1, 32'd3);
            check("bp_in2", in2, 32'd4);
        end
        m_ready = 1'b1;
        tick();
        s_valid = 1'b0;
        check("bp_cnt", WIDTH'(pair_cnt), 32'd3);
        check("bp_half_valid", WIDTH'(m_valid), 32'd0);
        check("bp_half_in1", in1, 32'd10);

        // Reset while half a pair is held
        send_word(32'd2, 1'b1);
        tick();
        send_word(32'd11, 1'b0);
        rst = 1'b1;
        tick();
        check("mid_rst_s_ready", WIDTH'(s_ready), 32'd0);
        check("mid_rst_in1", in1, 32'd0);
        check("mid_rst_cnt", WIDTH'(pair_cnt), 32'd0);
        rst = 1'b0;
        send_word(32'd1, 1'b0);
        send_word(32'd2, 1'b1);
        check("after_rst_in1", in1, 32'd1);
        check("after_rst_in2", in2, 32'd2);
        tick();
        check("after_rst_cnt", WIDTH'(pair_cnt), 32'd1);

        // Streaming rate: 32 words in 32 cycles form 16 pairs
        cnt0 = pair_cnt;
        stalls = 0;
        for (int i = 0; i < 32; i++) begin
            s_valid = 1'b1; s_data = $urandom; s_last = (i % 2 == 1);
            @(negedge clk);
            if (!s_ready) stalls++;
            tick();
        end
        s_valid = 1'b0; s_last = 1'b0;
        tick();
        check("stream_stalls", stalls, 32'd0);
        check("stream_pairs", WIDTH'(pair_cnt - cnt0), 32'd16);

        // Random operands 0..31 into the add stage
        sum0 = acc_sum; pairs0 = mdl_pairs; dsum0 = dut_sum; dpairs0 = dut_pairs;
        for (int i = 0; i < 800; i++) begin
            s_valid = ($urandom_range(0, 3) != 0);
            s_data  = $urandom_range(0, 31);
            s_last  = ($urandom_range(0, 3) == 0);
            m_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        s_valid = 1'b0; m_ready = 1'b1;
        tick();
        send_word(32'd0, 1'b1);
        tick();
        tick();
        check("rand_sum", dut_sum - dsum0, acc_sum - sum0);
        check("rand_pairs", dut_pairs - dpairs0, mdl_pairs - pairs0);

        // Counter wrap: 65537 padded pairs, one per cycle
        do_reset();
        for (int i = 0; i < 65537; i++) begin
            s_valid = 1'b1; s_data = $urandom; s_last = 1'b1;
            tick();
        end
        s_valid = 1'b0; s_last = 1'b0;
        tick();
        check("wrap_cnt", WIDTH'(pair_cnt), 32'd1);
        check("wrap_m_valid", WIDTH'(m_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
